// File: rtl/spi_slave_if.sv
// SPI mode-0 target: oversamples the SPI pins on clk, shifts MSB-first DATA_W-bit frames,
// and exposes a valid/ready TX holding register plus a one-cycle RX strobe.
`timescale 1ns/1ps
module spi_slave_if #(
    parameter int unsigned          DATA_W     = 8,
    parameter logic [DATA_W-1:0]    DEFAULT_TX = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state_q, state_d;

    logic [1:0] sclk_sync, ss_sync, mosi_sync;
    logic       sclk_d, ss_d;
    logic       sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              tx_ready_d, tx_underrun_d;
    logic [DATA_W-1:0] rx_data_d;
    logic              rx_valid_d, spi_miso_d, spi_miso_oe_d, busy_d;
    logic              load;

    // Two-flop synchronisers plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            ss_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            ss_sync   <= {ss_sync[0], spi_ss};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_d    <= sclk_sync[1];
            ss_d      <= ss_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[1] & sclk_d;
    assign ss_fall   = ~ss_sync[1] & ss_d;
    assign ss_rise   = ss_sync[1] & ~ss_d;
    assign mosi_s    = mosi_sync[1];

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            first_q     <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            hold_q      <= '0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            first_q     <= first_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            tx_ready    <= tx_ready_d;
            tx_underrun <= tx_underrun_d;
            rx_data     <= rx_data_d;
            rx_valid    <= rx_valid_d;
            spi_miso    <= spi_miso_d;
            spi_miso_oe <= spi_miso_oe_d;
            busy        <= busy_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        first_d       = first_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        hold_d        = hold_q;
        tx_ready_d    = tx_ready;
        tx_underrun_d = 1'b0;
        rx_data_d     = rx_data;
        rx_valid_d    = 1'b0;
        load          = 1'b0;

        if (tx_valid && tx_ready) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    first_d   = 1'b1;
                    load      = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    first_d    = 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // A falling edge ahead of the first rising edge must not consume a frame
                    if (bit_cnt_q == '0) begin
                        load = ~first_q;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A same-cycle accept into an empty register is not visible to this load
        if (load) begin
            if (!tx_ready) begin
                tx_shift_d = hold_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d    = DEFAULT_TX;
                tx_underrun_d = 1'b1;
            end
        end

        busy_d        = (state_d == ACTIVE);
        spi_miso_oe_d = (state_d == ACTIVE);
        spi_miso_d    = (state_d == ACTIVE) ? tx_shift_d[DATA_W-1] : 1'b0;
    end

endmodule
